// File: rtl/dbg_ctrl_pkg.sv
// Shared types for the debug run-control block: command opcodes, run states
// and halt causes.
package dbg_ctrl_pkg;

    localparam int NUM_BP = 2;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_HALT       = 3'd1,
        OP_RUN        = 3'd2,
        OP_STEP       = 3'd3,
        OP_SET_BP     = 3'd4,
        OP_CLR_BP     = 3'd5,
        OP_RESET_CORE = 3'd6,
        OP_ILLEGAL    = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_STEPPING = 2'd1,
        ST_HALTED   = 2'd2,
        ST_CORE_RST = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_CMD  = 2'd1,
        CAUSE_STEP = 2'd2,
        CAUSE_BP   = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/dbg_clk_gate.sv
// Latch-based clock gate for the core clock; the enable is captured while
// sysclk is low so dbgclk can never glitch during the high phase.
module dbg_clk_gate (
    input  logic sysclk,
    input  logic reset,
    input  logic en,
    output logic dbgclk
);

    logic en_q;

    // Reset clears the latch at once so dbgclk is held low while reset is high.
    always_latch begin
        if (reset) begin
            en_q <= 1'b0;
        end else if (!sysclk) begin
            en_q <= en;
        end
    end

    assign dbgclk = sysclk & en_q;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: gates the core clock and sequences
// run/halt/step/breakpoint/core-reset commands from the debug path.
module dbg_run_ctrl
    import dbg_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STEP_W       = 16,
    parameter int RST_CYCLES   = 4,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [XLEN-1:0]   cmd_arg,
    input  logic              cmd_bp_idx,
    output logic              cmd_err,
    input  logic [XLEN-1:0]   pc,
    output logic              core_en,
    output logic              dbgclk,
    output logic              dm_reset,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [STEP_W-1:0] step_remaining
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);
    localparam run_state_e RESET_STATE = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

    run_state_e        state_q, state_d;
    halt_cause_e       cause_q, cause_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              skip_q, skip_d;
    logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              bp_en_q   [NUM_BP];
    logic [XLEN-1:0]   bp_addr_q [NUM_BP];
    logic              cmd_err_q;
    logic              dm_reset_q;

    cmd_op_e           op;
    logic              accept;
    logic              active;
    logic              bp_match;
    logic              bp_hit;
    logic [STEP_W-1:0] step_arg;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = (state_q != ST_CORE_RST);
    assign accept    = cmd_valid & cmd_ready;
    assign active    = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign step_arg  = cmd_arg[STEP_W-1:0];

    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en_q[i] && (pc == bp_addr_q[i])) begin
                bp_match = 1'b1;
            end
        end
    end

    // skip masks the breakpoint at the PC we resume from until the core moves on.
    assign bp_hit  = bp_match & ~skip_q;
    assign core_en = active & ~bp_hit;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        step_d    = step_q;
        skip_d    = skip_q;
        rst_cnt_d = rst_cnt_q;

        if (core_en) begin
            skip_d = 1'b0;
        end

        if (state_q == ST_CORE_RST) begin
            if (rst_cnt_q == '0) begin
                state_d = ST_HALTED;
                cause_d = CAUSE_NONE;
                step_d  = '0;
            end else begin
                rst_cnt_d = rst_cnt_q - CNT_W'(1);
            end
        end else if (accept && (op == OP_RESET_CORE)) begin
            state_d   = ST_CORE_RST;
            rst_cnt_d = CNT_W'(RST_CYCLES - 1);
            cause_d   = CAUSE_NONE;
            step_d    = '0;
            skip_d    = 1'b0;
        end else if (active && bp_hit) begin
            // A breakpoint swallows any run/halt/step command in the same cycle.
            state_d = ST_HALTED;
            cause_d = CAUSE_BP;
        end else begin
            if ((state_q == ST_STEPPING) && core_en) begin
                step_d = step_q - STEP_W'(1);
                if (step_q == STEP_W'(1)) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            if (accept) begin
                case (op)
                    OP_HALT: begin
                        if (active) begin
                            state_d = ST_HALTED;
                            cause_d = CAUSE_CMD;
                        end
                    end
                    OP_RUN: begin
                        state_d = ST_RUNNING;
                        cause_d = CAUSE_NONE;
                        skip_d  = 1'b1;
                    end
                    OP_STEP: begin
                        state_d = ST_STEPPING;
                        cause_d = CAUSE_NONE;
                        step_d  = (step_arg == '0) ? STEP_W'(1) : step_arg;
                        skip_d  = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cause_q    <= CAUSE_NONE;
            step_q     <= '0;
            skip_q     <= 1'b0;
            rst_cnt_q  <= '0;
            cmd_err_q  <= 1'b0;
            dm_reset_q <= 1'b0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_en_q[i]   <= 1'b0;
                bp_addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            step_q     <= step_d;
            skip_q     <= skip_d;
            rst_cnt_q  <= rst_cnt_d;
            cmd_err_q  <= accept && (op == OP_ILLEGAL);
            dm_reset_q <= (state_d == ST_CORE_RST);
            if (accept && (op == OP_SET_BP)) begin
                bp_addr_q[cmd_bp_idx] <= cmd_arg;
                bp_en_q[cmd_bp_idx]   <= 1'b1;
            end else if (accept && (op == OP_CLR_BP)) begin
                bp_en_q[cmd_bp_idx]   <= 1'b0;
            end
        end
    end

    dbg_clk_gate u_clk_gate (
        .sysclk (sysclk),
        .reset  (reset),
        .en     (core_en),
        .dbgclk (dbgclk)
    );

    assign cmd_err        = cmd_err_q;
    assign dm_reset       = dm_reset_q;
    assign halted         = (state_q == ST_HALTED);
    assign halt_cause     = cause_q;
    assign step_remaining = step_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl: a vector table for single-command effects
// plus hand-written multi-cycle sequences against a toy core that adds 4 per edge.
module tb_dbg_run_ctrl;
    import dbg_ctrl_pkg::*;

    localparam int XLEN   = 32;
    localparam int STEP_W = 16;

    logic              sysclk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [XLEN-1:0]   cmd_arg;
    logic              cmd_bp_idx;
    logic              cmd_err;
    logic [XLEN-1:0]   core_pc;
    logic              core_en;
    logic              dbgclk;
    logic              dm_reset;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [STEP_W-1:0] step_remaining;

    int          checks   = 0;
    int          failures = 0;
    int unsigned dbg_pulses = 0;
    int unsigned base;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] arg;
        logic        idx;
        logic        halted;
        logic [1:0]  cause;
        logic        care_cause;
        logic [15:0] step;
        logic        core_en;
        logic        err;
    } vec_t;

    vec_t vecs [15];

    dbg_run_ctrl #(
        .XLEN         (XLEN),
        .STEP_W       (STEP_W),
        .RST_CYCLES   (4),
        .RUN_ON_RESET (1'b1)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .cmd_bp_idx     (cmd_bp_idx),
        .cmd_err        (cmd_err),
        .pc             (core_pc),
        .core_en        (core_en),
        .dbgclk         (dbgclk),
        .dm_reset       (dm_reset),
        .halted         (halted),
        .halt_cause     (halt_cause),
        .step_remaining (step_remaining)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge dbgclk) dbg_pulses <= dbg_pulses + 1;

    // Toy core: fetch PC advances by one word per gated clock edge.
    always @(posedge dbgclk or posedge reset or posedge dm_reset) begin
        if (reset || dm_reset) core_pc <= '0;
        else                   core_pc <= core_pc + 32'd4;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] arg, input logic idx);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_arg    = arg;
        cmd_bp_idx = idx;
        @(posedge sysclk);
        #1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_arg    = '0;
        cmd_bp_idx = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            op             arg           idx   hlt   cause care  step    en    err
        vecs[0]  = '{OP_NOP,        32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 16'd0, 1'b1, 1'b0};
        vecs[1]  = '{OP_HALT,       32'h0,        1'b0, 1'b1, 2'd1, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[2]  = '{OP_HALT,       32'h0,        1'b0, 1'b1, 2'd1, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[3]  = '{OP_ILLEGAL,    32'h0,        1'b0, 1'b1, 2'd1, 1'b1, 16'd0, 1'b0, 1'b1};
        vecs[4]  = '{OP_RUN,        32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 16'd0, 1'b1, 1'b0};
        vecs[5]  = '{OP_STEP,       32'h3,        1'b0, 1'b0, 2'd0, 1'b1, 16'd3, 1'b1, 1'b0};
        vecs[6]  = '{OP_NOP,        32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 16'd2, 1'b1, 1'b0};
        vecs[7]  = '{OP_NOP,        32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 16'd1, 1'b1, 1'b0};
        vecs[8]  = '{OP_NOP,        32'h0,        1'b0, 1'b1, 2'd2, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[9]  = '{OP_CLR_BP,     32'h0,        1'b1, 1'b1, 2'd2, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[10] = '{OP_SET_BP,     32'hFFFFFF00, 1'b1, 1'b1, 2'd2, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[11] = '{OP_STEP,       32'h0,        1'b0, 1'b0, 2'd0, 1'b0, 16'd1, 1'b1, 1'b0};
        vecs[12] = '{OP_NOP,        32'h0,        1'b0, 1'b1, 2'd2, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[13] = '{OP_RUN,        32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 16'd0, 1'b1, 1'b0};
        vecs[14] = '{OP_CLR_BP,     32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 16'd0, 1'b1, 1'b0};

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_arg    = '0;
        cmd_bp_idx = 1'b0;
        repeat (2) @(posedge sysclk);
        #2;
        checkOutput("rst.dbgclk_low", 32'(dbgclk), 32'd0);
        checkOutput("rst.core_en", 32'(core_en), 32'd1);
        checkOutput("rst.halted", 32'(halted), 32'd0);
        checkOutput("rst.cause", 32'(halt_cause), 32'd0);
        checkOutput("rst.step", 32'(step_remaining), 32'd0);
        checkOutput("rst.dm_reset", 32'(dm_reset), 32'd0);
        checkOutput("rst.cmd_err", 32'(cmd_err), 32'd0);
        @(negedge sysclk);
        reset = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].arg, vecs[i].idx);
            checkOutput($sformatf("vec%0d.halted", i), 32'(halted), 32'(vecs[i].halted));
            if (vecs[i].care_cause)
                checkOutput($sformatf("vec%0d.cause", i), 32'(halt_cause), 32'(vecs[i].cause));
            checkOutput($sformatf("vec%0d.step", i), 32'(step_remaining), 32'(vecs[i].step));
            checkOutput($sformatf("vec%0d.core_en", i), 32'(core_en), 32'(vecs[i].core_en));
            checkOutput($sformatf("vec%0d.cmd_err", i), 32'(cmd_err), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d.ready", i), 32'(cmd_ready), 32'd1);
        end

        $display("[TB] halt freezes dbgclk");
        applyStimulus(OP_HALT, 32'h0, 1'b0);
        base = dbg_pulses;
        idleCycles(5);
        checkOutput("halt.pulses", dbg_pulses - base, 32'd0);
        checkOutput("halt.halted", 32'(halted), 32'd1);
        checkOutput("halt.cause", 32'(halt_cause), 32'd1);

        $display("[TB] step 5");
        applyStimulus(OP_STEP, 32'd5, 1'b0);
        base = dbg_pulses;
        checkOutput("step5.rem_load", 32'(step_remaining), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            idleCycles(1);
            checkOutput($sformatf("step5.rem%0d", i), 32'(step_remaining), 32'(5 - i));
        end
        checkOutput("step5.halted", 32'(halted), 32'd1);
        checkOutput("step5.cause", 32'(halt_cause), 32'd2);
        idleCycles(2);
        checkOutput("step5.pulses", dbg_pulses - base, 32'd5);

        $display("[TB] step 0");
        applyStimulus(OP_STEP, 32'd0, 1'b0);
        base = dbg_pulses;
        idleCycles(3);
        checkOutput("step0.pulses", dbg_pulses - base, 32'd1);
        checkOutput("step0.halted", 32'(halted), 32'd1);
        checkOutput("step0.cause", 32'(halt_cause), 32'd2);

        $display("[TB] illegal op");
        applyStimulus(OP_ILLEGAL, 32'h0, 1'b0);
        checkOutput("ill.err_hi", 32'(cmd_err), 32'd1);
        checkOutput("ill.halted", 32'(halted), 32'd1);
        checkOutput("ill.cause", 32'(halt_cause), 32'd2);
        idleCycles(1);
        checkOutput("ill.err_lo", 32'(cmd_err), 32'd0);

        $display("[TB] reset core while running");
        applyStimulus(OP_RUN, 32'h0, 1'b0);
        idleCycles(2);
        applyStimulus(OP_RESET_CORE, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rstc.dm_reset%0d", i), 32'(dm_reset), 32'd1);
            checkOutput($sformatf("rstc.ready%0d", i), 32'(cmd_ready), 32'd0);
            idleCycles(1);
        end
        checkOutput("rstc.halted", 32'(halted), 32'd1);
        checkOutput("rstc.cause", 32'(halt_cause), 32'd0);
        checkOutput("rstc.dm_reset_lo", 32'(dm_reset), 32'd0);
        checkOutput("rstc.ready", 32'(cmd_ready), 32'd1);
        checkOutput("rstc.pc", core_pc, 32'h0);

        $display("[TB] breakpoint at 0x10");
        applyStimulus(OP_SET_BP, 32'h10, 1'b0);
        applyStimulus(OP_RUN, 32'h0, 1'b0);
        base = dbg_pulses;
        idleCycles(4);
        checkOutput("bp.pc_at_bp", core_pc, 32'h10);
        checkOutput("bp.core_en_gated", 32'(core_en), 32'd0);
        checkOutput("bp.not_yet_halted", 32'(halted), 32'd0);
        idleCycles(1);
        checkOutput("bp.halted", 32'(halted), 32'd1);
        checkOutput("bp.cause", 32'(halt_cause), 32'd3);
        checkOutput("bp.pulses", dbg_pulses - base, 32'd4);
        applyStimulus(OP_RUN, 32'h0, 1'b0);
        idleCycles(6);
        checkOutput("bp.resume_halted", 32'(halted), 32'd0);
        checkOutput("bp.resume_pc", core_pc, 32'h28);

        $display("[TB] breakpoint kept across core reset");
        applyStimulus(OP_RESET_CORE, 32'h0, 1'b0);
        idleCycles(4);
        checkOutput("bpkeep.halted", 32'(halted), 32'd1);
        checkOutput("bpkeep.pc", core_pc, 32'h0);
        applyStimulus(OP_RUN, 32'h0, 1'b0);
        idleCycles(5);
        checkOutput("bpkeep.halted_bp", 32'(halted), 32'd1);
        checkOutput("bpkeep.cause", 32'(halt_cause), 32'd3);
        checkOutput("bpkeep.pc_at_bp", core_pc, 32'h10);

        $display("[TB] step 10 into breakpoint");
        applyStimulus(OP_SET_BP, 32'h1C, 1'b1);
        applyStimulus(OP_STEP, 32'd10, 1'b0);
        idleCycles(4);
        checkOutput("stepbp.halted", 32'(halted), 32'd1);
        checkOutput("stepbp.cause", 32'(halt_cause), 32'd3);
        checkOutput("stepbp.rem", 32'(step_remaining), 32'd7);
        checkOutput("stepbp.pc", core_pc, 32'h1C);

        $display("[TB] halt coincident with breakpoint");
        applyStimulus(OP_SET_BP, 32'h20, 1'b1);
        applyStimulus(OP_RUN, 32'h0, 1'b0);
        idleCycles(1);
        checkOutput("haltbp.pc", core_pc, 32'h20);
        checkOutput("haltbp.core_en", 32'(core_en), 32'd0);
        checkOutput("haltbp.pre_halted", 32'(halted), 32'd0);
        applyStimulus(OP_HALT, 32'h0, 1'b0);
        checkOutput("haltbp.halted", 32'(halted), 32'd1);
        checkOutput("haltbp.cause", 32'(halt_cause), 32'd3);

        $display("[TB] reset mid-step");
        applyStimulus(OP_STEP, 32'd100, 1'b0);
        idleCycles(2);
        checkOutput("midrst.rem", 32'(step_remaining), 32'd98);
        @(posedge sysclk);
        #2;
        checkOutput("midrst.dbgclk_hi", 32'(dbgclk), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midrst.dbgclk_lo", 32'(dbgclk), 32'd0);
        checkOutput("midrst.rem0", 32'(step_remaining), 32'd0);
        checkOutput("midrst.halted", 32'(halted), 32'd0);
        checkOutput("midrst.cause", 32'(halt_cause), 32'd0);
        @(negedge sysclk);
        reset = 1'b0;
        idleCycles(6);
        checkOutput("midrst.bp_cleared", 32'(halted), 32'd0);
        checkOutput("midrst.pc", core_pc, 32'h18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Debug run-control sequencer for the RISC-V core. It owns the core's gated clock (`dbgclk`) and the debug reset (`dm_reset`), and executes run/halt/step/breakpoint commands arriving from the JTAG debug path. It sits between the JTAG test logic and the core, replacing free-running `dbgclk` generation. Commands are already synchronized into the `sysclk` domain.

## Interface
- `XLEN`, 32: PC / breakpoint address width
- `STEP_W`, 16: step counter width
- `RST_CYCLES`, 4: `dm_reset` pulse length in `sysclk` cycles
- `RUN_ON_RESET`, 1: state after `reset` (1 = RUNNING, 0 = HALTED)

Ports:
- `sysclk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command strobe
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_op`  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 RESET_CORE; 7 is illegal
- `cmd_arg`  in  XLEN  step count (STEP) or breakpoint address (SET_BP)
- `cmd_bp_idx`  in  1  breakpoint slot for SET_BP / CLR_BP
- `cmd_err`  out  1  one-cycle pulse when op 7 is accepted
- `pc`  in  XLEN  core fetch PC (PCF)
- `core_en`  out  1  core clock enable (combinational)
- `dbgclk`  out  1  gated clock to core and dmem
- `dm_reset`  out  1  core reset pulse (registered)
- `halted`  out  1  state == HALTED
- `halt_cause`  out  2  0 NONE, 1 CMD, 2 STEP, 3 BP
- `step_remaining`  out  STEP_W  remaining step count

## Operation
- States:
  - RUNNING: `core_en = !bp_hit`
  - STEPPING: `core_en = !bp_hit`
  - HALTED: `core_en = 0`
  - CORE_RST: `core_en = 0`, `dm_reset = 1`
- Breakpoints:
  - `bp_hit = |(bp_en[i] & pc == bp_addr[i]) & !skip`, over 2 slots.
  - `bp_hit` in RUNNING or STEPPING moves the state to HALTED with cause BP.
  - `skip` is set when RUN or STEP is accepted and cleared at the first enabled core edge. This lets execution resume from a breakpoint PC.
- HALT:
  - From RUNNING or STEPPING: go to HALTED, cause CMD.
  - In HALTED: no-op.
- RUN: go to RUNNING, cause NONE.
- STEP N:
  - Load `step_remaining` with `cmd_arg[STEP_W-1:0]`; N = 0 is treated as 1.
  - Go to STEPPING.
  - Decrement at each enabled edge. The 1→0 transition moves to HALTED, cause STEP.
- SET_BP / CLR_BP:
  - Write `bp_addr` / `bp_en` for the slot.
  - Legal in any non-CORE_RST state; no state change.
  - Effective from the next cycle.
- RESET_CORE:
  - Accepted in any state.
  - Go to CORE_RST for exactly RST_CYCLES cycles, then HALTED with cause NONE and `step_remaining = 0`.
  - Breakpoint configuration is retained.
- `cmd_ready = (state != CORE_RST)`.
- Priority within one cycle: RESET_CORE cmd > `bp_hit` > other cmd > step completion.
  - HALT accepted during `bp_hit` is consumed; cause is BP.
- `bp_hit` during STEPPING blocks the edge, so no decrement; `step_remaining` holds its value.
- Reset values:
  - state = RUN_ON_RESET ? RUNNING : HALTED
  - `core_en` follows state; `halted = !RUN_ON_RESET`
  - `dm_reset = 0`, `halt_cause = 0`, `step_remaining = 0`, `cmd_err = 0`
  - `bp_en = 0`, `bp_addr = 0`, `skip = 0`

## Timing
- A core edge occurs on `sysclk` rising edge e iff `core_en = 1` in the cycle before e.
- RUN accepted at edge k: `core_en = 1` from cycle k+1; first core edge is k+1.
- STEP N accepted at edge k: core edges k+1..k+N exactly; `halted` rises after edge k+N.
- HALT accepted at edge k: last core edge is k if `core_en` was already high; none after.
- `bp_hit` gates `core_en` in the same cycle (`pc → core_en` path is combinational). The core stops with PCF == breakpoint address; state updates at the next edge.
- RESET_CORE accepted at edge k: `dm_reset` is high after edges k..k+RST_CYCLES-1; HALTED after edge k+RST_CYCLES.
- `cmd_err` is high for the one cycle after acceptance.
- `reset` mid-operation: all registers return to reset values immediately; `dbgclk` is low while `reset` is asserted.

## Structure
- Package `dbg_ctrl_pkg`: `cmd_op_e`, `run_state_e`, `halt_cause_e` enums; `NUM_BP = 2`.
- Sub-module `dbg_clk_gate`: latch-based ICG. Latch `core_en` while `sysclk` is low; `dbgclk = sysclk & en_q`. Isolates the only latch in the design.

## Test plan
- Reset with RUN_ON_RESET=1 → `core_en = 1`, `halted = 0`, `halt_cause = 0`; HALT → `halted = 1`, cause 1, `dbgclk` flat.
- From HALTED, STEP 5 → exactly 5 `dbgclk` pulses, `step_remaining` 5→0, cause 2. STEP 0 → exactly 1 pulse.
- SET_BP slot 0 = 0x10, then RUN with program at 0 → halts with `pc = 0x10`, cause 3. RUN again → passes 0x10 and does not re-halt there.
- STEP 10 with breakpoint reached after 3 edges → halts with cause 3, `step_remaining = 7`.
- RESET_CORE while RUNNING → `cmd_ready = 0` and `dm_reset = 1` for 4 cycles, then HALTED, cause 0. Breakpoint at 0x10 still hits after a subsequent RUN.
- HALT issued in the same cycle as `bp_hit` → cause 3. `cmd_op = 7` → `cmd_err` pulses once, state unchanged.
